switch_event_ctrl: RTL and testbench
====================================

Name: switch_event_ctrl

Overview:
- Sequencer and arbiter sitting behind the 4-bit switch debouncer.
- Converts debounced switch levels into discrete press, release and auto-repeat events.
- Shares one event queue among the four switches using round-robin arbitration.
- Delivers events to downstream logic through a 4-deep FIFO with a valid/ready handshake.

Parameters:
- TICK_DIV, 50: clock cycles per repeat tick (prescaler period), range 2..255.
- REPEAT_DELAY, 20: ticks a switch must stay held before its first repeat event, range 1..255.
- REPEAT_RATE, 5: ticks between later repeat events while still held, range 1..255.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- iSWITCH  input  4  debounced switch levels; 1 = pressed.
- iEVT_READY  input  1  consumer accepts the head event this cycle.
- oEVT_VALID  output  1  FIFO not empty; oEVT_CODE is valid.
- oEVT_CODE  output  4  {type[1:0], idx[1:0]}. Types: 00 press, 01 release, 10 repeat; 11 is never emitted.
- oDROP  output  1  sticky flag: a pending event was lost. Cleared only by RST.

Behaviour:
- Reset (async, RST=1) clears the following to 0:
  - prescaler, sw_q, sw_prev, all pending bits, hold counters, RR pointer;
  - FIFO pointers and count, oEVT_VALID, oEVT_CODE, oDROP.
- A switch already held when RST releases produces a press event (sw_prev resets to 0).
- Input sampling:
  - sw_q <= iSWITCH every cycle; sw_prev <= sw_q.
  - rise[i] = sw_q[i] & ~sw_prev[i]; fall[i] = ~sw_q[i] & sw_prev[i].
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when the count equals TICK_DIV-1.
- Hold counter per switch (8-bit):
  - Cleared while sw_q[i] = 0 and on rise[i].
  - While held, increments on tick.
  - On reaching REPEAT_DELAY: set rep_pend[i] and reload to REPEAT_DELAY-REPEAT_RATE, so later repeats fire every REPEAT_RATE ticks.
  - Never wraps past 255.
- Pending bits per switch: press_pend, rel_pend, rep_pend.
  - Set on rise, fall and repeat-fire respectively.
  - Setting a bit that is already 1 (and not being granted in the same cycle) sets oDROP; the bit stays 1, so events merge.
  - On fall[i], rep_pend[i] is cleared without setting oDROP.
- Arbiter (combinational grant, registered effect):
  - Grants only when the FIFO is not full. Full is judged on the registered count before this cycle's pop, so a simultaneous pop does not unblock a push.
  - Searches switches starting at the RR pointer, ascending mod 4. The first switch with any pending bit wins.
  - Within the winning switch, order is press, then repeat, then release. Exactly one event is granted per cycle.
  - The granted pending bit clears; the event is pushed into the FIFO; RR pointer <= winner+1 mod 4.
  - If a set and a grant of the same bit coincide, the set wins, the bit stays 1 and oDROP does not assert.
- FIFO (depth 4):
  - Push on grant; pop when oEVT_VALID & iEVT_READY.
  - Simultaneous push and pop is legal when not full; count is unchanged.
  - oEVT_VALID = (count != 0), registered.
  - oEVT_CODE shows the head entry. It is held stable while oEVT_VALID & ~iEVT_READY.
  - Pop on empty is ignored. Pointers wrap mod 4.
- Latency:
  - iSWITCH edge sampled at clock edge k sets pend at edge k+1, and the FIFO write happens at edge k+2.
  - oEVT_VALID is high after edge k+2 when there is no contention and the FIFO was empty.
- Back-pressure: while the FIFO is full, pending bits accumulate and are merged or dropped per the rules above. No events are lost silently: every loss sets oDROP.
- RST asserted mid-operation discards all queued and pending events immediately.

Test Plan:
- Reset/idle: RST=1 then released, iSWITCH=0 for 100 cycles -> oEVT_VALID=0, oDROP=0, oEVT_CODE=0 throughout.
- Single press/release, iEVT_READY=1: iSWITCH=0001 for 10 cycles, then 0000 -> code 0000 (press) valid 3 cycles after the rise, then code 0100 (release); each valid for one cycle.
- Round-robin: iEVT_READY=0; iSWITCH 0000 -> 1111 in one cycle -> FIFO fills with 0000, 0001, 0010, 0011 in that order. Then release ready, set iSWITCH=0000 -> releases are emitted in order 0100, 0101, 0110, 0111.
- Auto-repeat with TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2: hold switch 2 for 40 cycles, iEVT_READY=1 -> press 0010, first repeat 1010 about 12 cycles after the press, then a repeat every 8 cycles; release 0110 follows and no repeat appears after it.
- Overflow: iEVT_READY=0; toggle switch 0 five times -> FIFO holds 4 events, oDROP=1 and stays 1. oEVT_CODE does not change while stalled.
- Async reset mid-stream: FIFO holding 3 events, assert RST between clock edges -> oEVT_VALID=0 and oDROP=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/switch_event_ctrl.sv
// switch_event_ctrl: turns debounced switch levels into press/release/repeat
// events, arbitrates the four switches round-robin and queues the events in a
// 4-deep valid/ready FIFO. oDROP latches any event lost to merging.
module switch_event_ctrl #(
    parameter int unsigned TICK_DIV     = 50,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] iSWITCH,
    input  logic       iEVT_READY,
    output logic       oEVT_VALID,
    output logic [3:0] oEVT_CODE,
    output logic       oDROP
);

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [7:0] DELAY_V   = 8'(REPEAT_DELAY);
    // A rate longer than the delay has no meaningful reload; fall back to
    // restarting from zero so repeats keep coming every REPEAT_DELAY ticks.
    localparam logic [7:0] RELOAD_V  = (REPEAT_RATE < REPEAT_DELAY) ?
                                       8'(REPEAT_DELAY - REPEAT_RATE) : 8'd0;

    localparam logic [1:0] T_PRESS   = 2'b00;
    localparam logic [1:0] T_RELEASE = 2'b01;
    localparam logic [1:0] T_REPEAT  = 2'b10;

    logic [7:0]      presc_q, presc_d;
    logic [3:0]      sw_q, sw_prev_q;
    logic [3:0][7:0] hold_q, hold_d;
    logic [3:0]      press_pend_q, press_pend_d;
    logic [3:0]      rel_pend_q, rel_pend_d;
    logic [3:0]      rep_pend_q, rep_pend_d;
    logic [1:0]      rr_q, rr_d;
    logic [3:0][3:0] mem_q, mem_d;
    logic [1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [2:0]      count_q, count_d;
    logic            valid_q, valid_d;
    logic [3:0]      code_q, code_d;
    logic            drop_q, drop_d;

    logic            tick;
    logic [3:0]      rise, fall, rep_fire;
    logic            full, push, pop;
    logic            grant_vld;
    logic [1:0]      grant_idx, grant_type;
    logic [3:0]      gnt_press, gnt_rel, gnt_rep;
    logic [3:0]      any_pend;

    assign tick = (presc_q == TICK_LAST);
    assign rise = sw_q & ~sw_prev_q;
    assign fall = ~sw_q & sw_prev_q;

    assign presc_d = tick ? 8'd0 : presc_q + 8'd1;

    // Per-switch hold timer: counts ticks while held, fires a repeat on reaching the delay
    always_comb begin
        hold_d   = hold_q;
        rep_fire = '0;
        for (int i = 0; i < 4; i++) begin
            if (!sw_q[i] || rise[i]) begin
                hold_d[i] = 8'd0;
            end else if (tick && hold_q[i] != 8'hFF) begin
                if (hold_q[i] + 8'd1 == DELAY_V) begin
                    rep_fire[i] = 1'b1;
                    hold_d[i]   = RELOAD_V;
                end else begin
                    hold_d[i] = hold_q[i] + 8'd1;
                end
            end
        end
    end

    assign full     = (count_q == 3'd4);
    assign any_pend = press_pend_q | rel_pend_q | rep_pend_q;

    // Round-robin grant from the RR pointer; within a switch press beats repeat beats release
    always_comb begin
        logic [1:0] cand;
        cand       = rr_q;
        grant_vld  = 1'b0;
        grant_idx  = 2'd0;
        grant_type = T_PRESS;
        gnt_press  = '0;
        gnt_rel    = '0;
        gnt_rep    = '0;
        if (!full) begin
            for (int k = 0; k < 4; k++) begin
                cand = rr_q + 2'(k);
                if (!grant_vld && any_pend[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_vld) begin
            if (press_pend_q[grant_idx]) begin
                grant_type           = T_PRESS;
                gnt_press[grant_idx] = 1'b1;
            end else if (rep_pend_q[grant_idx]) begin
                grant_type         = T_REPEAT;
                gnt_rep[grant_idx] = 1'b1;
            end else begin
                grant_type         = T_RELEASE;
                gnt_rel[grant_idx] = 1'b1;
            end
        end
    end

    // Pending bits: a new set always wins over a grant; re-setting an ungranted bit is a loss
    always_comb begin
        press_pend_d = (press_pend_q & ~gnt_press) | rise;
        rel_pend_d   = (rel_pend_q & ~gnt_rel) | fall;
        rep_pend_d   = ((rep_pend_q & ~gnt_rep) | rep_fire) & ~fall;
        drop_d       = drop_q
                     | (|(rise & press_pend_q & ~gnt_press))
                     | (|(fall & rel_pend_q & ~gnt_rel))
                     | (|(rep_fire & rep_pend_q & ~gnt_rep));
        rr_d         = grant_vld ? grant_idx + 2'd1 : rr_q;
    end

    assign push = grant_vld;
    assign pop  = (count_q != 3'd0) && iEVT_READY;

    // FIFO bookkeeping; the head code is registered so the output is a clean flop
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = {grant_type, grant_idx};
        end
        wr_d    = wr_q + {1'b0, push};
        rd_d    = rd_q + {1'b0, pop};
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        valid_d = (count_d != 3'd0);
        code_d  = valid_d ? mem_d[rd_d] : 4'd0;
    end

    // State registers, all cleared asynchronously by RST
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q      <= '0;
            sw_q         <= '0;
            sw_prev_q    <= '0;
            hold_q       <= '0;
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            rep_pend_q   <= '0;
            rr_q         <= '0;
            mem_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            code_q       <= '0;
            drop_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sw_q         <= iSWITCH;
            sw_prev_q    <= sw_q;
            hold_q       <= hold_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            rep_pend_q   <= rep_pend_d;
            rr_q         <= rr_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            drop_q       <= drop_d;
        end
    end

    assign oEVT_VALID = valid_q;
    assign oEVT_CODE  = code_q;
    assign oDROP      = drop_q;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Bench for switch_event_ctrl: queue-based event model compared every cycle,
// directed scenarios with literal expectations, then randomized switching.
module tb_switch_event_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int REPEAT_DELAY = 3;
    localparam int REPEAT_RATE  = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] iSWITCH = 4'd0;
    logic       iEVT_READY = 1'b0;
    logic       oEVT_VALID;
    logic [3:0] oEVT_CODE;
    logic       oDROP;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    switch_event_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iSWITCH   (iSWITCH),
        .iEVT_READY(iEVT_READY),
        .oEVT_VALID(oEVT_VALID),
        .oEVT_CODE (oEVT_CODE),
        .oDROP     (oDROP)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_presc;
    bit   [3:0] m_sw, m_prev;
    int         m_held [4];     // ticks held since the press was seen
    bit   [3:0] m_pp, m_pr, m_prep;
    int         m_rr;
    bit         m_drop;
    logic [3:0] m_q [$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_presc = 0; m_sw = 0; m_prev = 0; m_rr = 0; m_drop = 0;
            m_pp = 0; m_pr = 0; m_prep = 0;
            for (int s = 0; s < 4; s++) m_held[s] = 0;
            m_q.delete();
        end else begin
            bit tick, pop, rise, fall, fire;
            int win;
            logic [1:0] typ;
            bit [3:0] gp, gr, gq;
            tick = (m_presc == TICK_DIV - 1);
            win = -1; typ = 2'b00; gp = 0; gr = 0; gq = 0;
            if (m_q.size() < 4)
                for (int k = 0; k < 4; k++)
                    if (win < 0 && (m_pp[(m_rr + k) % 4] || m_pr[(m_rr + k) % 4] || m_prep[(m_rr + k) % 4]))
                        win = (m_rr + k) % 4;
            if (win >= 0) begin
                if (m_pp[win])        begin typ = 2'b00; gp[win] = 1; end
                else if (m_prep[win]) begin typ = 2'b10; gq[win] = 1; end
                else                  begin typ = 2'b01; gr[win] = 1; end
            end
            pop = (m_q.size() > 0) && iEVT_READY;
            for (int s = 0; s < 4; s++) begin
                rise = m_sw[s] && !m_prev[s];
                fall = !m_sw[s] && m_prev[s];
                fire = 0;
                if (m_sw[s] && !rise) begin
                    if (tick) begin
                        m_held[s]++;
                        if (m_held[s] >= REPEAT_DELAY && (m_held[s] - REPEAT_DELAY) % REPEAT_RATE == 0)
                            fire = 1;
                    end
                end else m_held[s] = 0;
                if (rise) begin if (m_pp[s] && !gp[s]) m_drop = 1; m_pp[s] = 1; end
                else if (gp[s]) m_pp[s] = 0;
                if (fall) begin if (m_pr[s] && !gr[s]) m_drop = 1; m_pr[s] = 1; end
                else if (gr[s]) m_pr[s] = 0;
                if (fall) m_prep[s] = 0;
                else if (fire) begin if (m_prep[s] && !gq[s]) m_drop = 1; m_prep[s] = 1; end
                else if (gq[s]) m_prep[s] = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (win >= 0) begin
                m_q.push_back({typ, 2'(win)});
                m_rr = (win + 1) % 4;
            end
            m_presc = (m_presc + 1) % TICK_DIV;
            m_prev  = m_sw;
            m_sw    = iSWITCH;
        end
    end

    // Every-cycle compare against the model
    bit cmp_en = 0;
    always @(negedge CLK) begin
        if (cmp_en && !RST) begin
            check("model_valid", int'(oEVT_VALID), int'(m_q.size() != 0));
            check("model_drop", int'(oDROP), int'(m_drop));
            if (m_q.size() != 0) check("model_code", int'(oEVT_CODE), int'(m_q[0]));
        end
    end

    // Record every accepted event with its cycle
    bit rec_en = 0;
    int rec_code [$];
    int rec_cyc  [$];
    always @(negedge CLK) begin
        if (rec_en && !RST && oEVT_VALID && iEVT_READY) begin
            rec_code.push_back(int'(oEVT_CODE));
            rec_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RST = 1'b1; iSWITCH = 4'd0; iEVT_READY = 1'b0;
        step(2);
        RST = 1'b0;
        step(1);
    endtask

    initial begin
        int errs, nrep, gap;
        int bitn;
        cmp_en = 1;
        @(posedge CLK); #2;
        do_reset();

        // idle after reset
        check("reset_valid", int'(oEVT_VALID), 0);
        check("reset_drop", int'(oDROP), 0);
        check("reset_code", int'(oEVT_CODE), 0);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (oEVT_VALID || oDROP || oEVT_CODE != 4'd0) errs++;
        end
        check("idle_quiet", errs, 0);

        // single press / release with ready high
        iEVT_READY = 1'b1; iSWITCH = 4'b0001;
        step(2);
        check("press_not_yet", int'(oEVT_VALID), 0);
        step(1);
        check("press_valid", int'(oEVT_VALID), 1);
        check("press_code", int'(oEVT_CODE), 4'b0000);
        step(1);
        check("press_one_cycle", int'(oEVT_VALID), 0);
        step(2);
        iSWITCH = 4'b0000;
        step(2);
        check("release_not_yet", int'(oEVT_VALID), 0);
        step(1);
        check("release_valid", int'(oEVT_VALID), 1);
        check("release_code", int'(oEVT_CODE), 4'b0100);
        step(1);
        check("release_one_cycle", int'(oEVT_VALID), 0);

        // round robin: all four pressed at once while stalled
        do_reset();
        iSWITCH = 4'hF;
        step(5);
        check("rr_head", int'(oEVT_CODE), 4'b0000);
        step(1);
        rec_code.delete(); rec_cyc.delete(); rec_en = 1;
        iEVT_READY = 1'b1; iSWITCH = 4'h0;
        for (int i = 0; i < 40 && rec_code.size() < 8; i++) step(1);
        step(4);
        rec_en = 0;
        check("rr_count", rec_code.size(), 8);
        errs = 0;
        for (int i = 0; i < rec_code.size() && i < 8; i++)
            if (rec_code[i] != i) errs++;
        check("rr_order", errs, 0);
        check("rr_no_drop", int'(oDROP), 0);

        // auto-repeat on switch 2
        do_reset();
        rec_code.delete(); rec_cyc.delete(); rec_en = 1;
        iEVT_READY = 1'b1; iSWITCH = 4'b0100;
        step(40);
        iSWITCH = 4'b0000;
        step(20);
        rec_en = 0;
        check("rep_total", rec_code.size(), 6);
        if (rec_code.size() == 6) begin
            check("rep_first_press", rec_code[0], 4'b0010);
            check("rep_last_release", rec_code[5], 4'b0110);
            nrep = 0;
            for (int i = 1; i < 5; i++) if (rec_code[i] == 4'b1010) nrep++;
            check("rep_count", nrep, 4);
            gap = rec_cyc[1] - rec_cyc[0];
            check("rep_first_gap_ok", int'(gap >= 9 && gap <= 12), 1);
            errs = 0;
            for (int i = 2; i < 5; i++) if (rec_cyc[i] - rec_cyc[i-1] != 8) errs++;
            check("rep_period", errs, 0);
        end

        // overflow while stalled
        do_reset();
        for (int t = 0; t < 5; t++) begin
            iSWITCH = 4'b0001; step(2);
            iSWITCH = 4'b0000; step(2);
        end
        step(4);
        check("ovf_valid", int'(oEVT_VALID), 1);
        check("ovf_drop", int'(oDROP), 1);
        check("ovf_head", int'(oEVT_CODE), 4'b0000);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (oEVT_CODE != 4'b0000 || !oEVT_VALID || !oDROP) errs++;
        end
        check("ovf_stall_stable", errs, 0);

        // async reset between edges clears outputs immediately
        #1 RST = 1'b1;
        #1;
        check("async_valid", int'(oEVT_VALID), 0);
        check("async_drop", int'(oDROP), 0);
        check("async_code", int'(oEVT_CODE), 0);
        step(1);
        RST = 1'b0;
        step(1);

        // randomized switching with varying back-pressure and periodic resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                bitn = $urandom_range(3);
                iSWITCH[bitn] = ~iSWITCH[bitn];
            end
            if (c % 400 < 250) iEVT_READY = ($urandom_range(3) != 0);
            else               iEVT_READY = ($urandom_range(7) == 0);
            if (c % 1000 == 999) begin
                RST = 1'b1;
                step(1);
                RST = 1'b0;
            end
            step(1);
        end

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
